// File: rtl/prim_prince_ctr_stream.sv
// rtl/prim_prince_ctr_stream.sv - counter-mode keystream controller driving prim_prince
// Issues {nonce, ctr} blocks under a 2-entry credit, buffers keystream, XORs it onto the data stream.
module prim_prince_ctr_stream #(
  parameter int DataWidth     = 64,
  parameter int NonceWidth    = 32,
  parameter int CipherLatency = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [NonceWidth-1:0] req_nonce_i,
  input  logic [7:0]            req_len_i,
  input  logic                  data_valid_i,
  output logic                  data_ready_o,
  input  logic [DataWidth-1:0]  data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DataWidth-1:0]  out_data_o,
  output logic                  out_last_o,
  output logic                  cipher_valid_o,
  output logic [DataWidth-1:0]  cipher_data_o,
  output logic                  cipher_dec_o,
  input  logic                  cipher_valid_i,
  input  logic [DataWidth-1:0]  cipher_data_i,
  output logic                  err_o
);
  localparam int CtrWidth = DataWidth - NonceWidth;

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e                r_state, w_state_nxt;
  logic [NonceWidth-1:0] r_nonce;
  logic [7:0]            r_len, r_iss, r_con;
  logic [1:0]            r_inf, r_cnt;
  logic [DataWidth-1:0]  r_fifo [2];
  logic                  r_wptr, r_rptr, r_err;

  logic                  w_accept, w_issue, w_pop, w_resp_ok, w_stray, w_last;
  logic [1:0]            w_inf;
  logic [2:0]            w_credit;

  // A zero-latency cipher answers in the issue cycle, so nothing is ever in flight at an edge.
  assign w_inf = (CipherLatency == 0) ? 2'd0 : r_inf;

  assign out_valid_o  = (r_cnt != 2'd0) && data_valid_i;
  assign data_ready_o = (r_cnt != 2'd0) && out_ready_i;
  assign w_pop        = out_valid_o && out_ready_i;
  assign w_last       = (r_con == r_len - 8'd1);
  assign out_last_o   = out_valid_o && w_last;
  assign out_data_o   = r_fifo[r_rptr] ^ data_i;

  assign w_credit       = {1'b0, r_cnt} + {1'b0, w_inf} - {2'b0, w_pop};
  assign w_issue        = (r_state == ST_RUN) && (r_iss < r_len) && (w_credit < 3'd2);
  assign cipher_valid_o = w_issue;
  assign cipher_data_o  = {r_nonce, {(CtrWidth-8){1'b0}}, r_iss};
  assign cipher_dec_o   = 1'b0;

  // A response is only accepted against an outstanding or same-cycle request.
  assign w_resp_ok = cipher_valid_i && ((w_inf != 2'd0) || w_issue);
  assign w_stray   = cipher_valid_i && !w_resp_ok;
  assign err_o     = r_err;

  always_comb begin
    w_state_nxt = r_state;
    req_ready_o = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        w_accept    = req_valid_i;
        if (req_valid_i && (req_len_i != 8'd0)) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_pop && w_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_nonce   <= '0;
      r_len     <= '0;
      r_iss     <= '0;
      r_con     <= '0;
      r_inf     <= '0;
      r_cnt     <= '0;
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_nonce <= req_nonce_i;
        r_len   <= req_len_i;
        r_iss   <= '0;
        r_con   <= '0;
        r_inf   <= '0;
        r_cnt   <= '0;
        r_wptr  <= 1'b0;
        r_rptr  <= 1'b0;
      end else begin
        if (w_issue) r_iss <= r_iss + 8'd1;
        if (w_pop) begin
          r_con  <= r_con + 8'd1;
          r_rptr <= ~r_rptr;
        end
        if (w_resp_ok) begin
          r_fifo[r_wptr] <= cipher_data_i;
          r_wptr         <= ~r_wptr;
        end
        r_inf <= r_inf + {1'b0, w_issue} - {1'b0, w_resp_ok};
        r_cnt <= r_cnt + {1'b0, w_resp_ok} - {1'b0, w_pop};
      end
      if (w_stray && (r_state == ST_RUN)) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_prim_prince_ctr_stream.sv
// tb/tb_prim_prince_ctr_stream.sv - randomized scoreboard bench for prim_prince_ctr_stream
module tb_prim_prince_ctr_stream;
  localparam int LAT = 1;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o;
  logic [31:0] req_nonce_i;
  logic [7:0]  req_len_i;
  logic        data_valid_i, data_ready_o;
  logic [63:0] data_i;
  logic        out_valid_o, out_ready_i, out_last_o;
  logic [63:0] out_data_o;
  logic        cipher_valid_o, cipher_dec_o, cipher_valid_i;
  logic [63:0] cipher_data_o, cipher_data_i;
  logic        err_o;

  always #5 clk_i = ~clk_i;

  prim_prince_ctr_stream #(.DataWidth(64), .NonceWidth(32), .CipherLatency(LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_nonce_i(req_nonce_i), .req_len_i(req_len_i),
    .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_i(data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_last_o(out_last_o),
    .cipher_valid_o(cipher_valid_o), .cipher_data_o(cipher_data_o), .cipher_dec_o(cipher_dec_o),
    .cipher_valid_i(cipher_valid_i), .cipher_data_i(cipher_data_i),
    .err_o(err_o)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          ks_ones  = 1'b0;
  bit          fixed_data = 1'b0;
  bit          exp_err  = 1'b0;
  logic        pend_v   = 1'b0;
  logic [63:0] pend_d   = '0;
  logic [63:0] last_out = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Stand-in cipher: any fixed bijection-like mix is enough to tie output to {nonce, index}.
  function automatic logic [63:0] ks(input logic [63:0] x);
    if (ks_ones) return '1;
    return ({x[31:0], x[63:32]} ^ (x << 7)) ^ 64'h9E37_79B9_7F4A_7C15;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic reset_dut();
    rst_i = 1'b1; req_valid_i = 1'b0; data_valid_i = 1'b0; out_ready_i = 1'b0;
    cipher_valid_i = 1'b0; cipher_data_i = rnd64(); pend_v = 1'b0; data_i = rnd64();
    @(posedge clk_i); #1;
    data_i = rnd64();
    #3;
    check_eq("rst_req_ready", req_ready_o, 1);
    check_eq("rst_data_ready", data_ready_o, 0);
    check_eq("rst_out_valid", out_valid_o, 0);
    check_eq("rst_out_data", out_data_o, data_i);
    check_eq("rst_out_last", out_last_o, 0);
    check_eq("rst_cipher_valid", cipher_valid_o, 0);
    check_eq("rst_cipher_data", cipher_data_o, 0);
    check_eq("rst_cipher_dec", cipher_dec_o, 0);
    check_eq("rst_err", err_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid_i = 1'b0; data_valid_i = 1'b1; out_ready_i = 1'b1; data_i = rnd64();
      cipher_valid_i = pend_v; cipher_data_i = pend_d;
      #3;
      check_eq("idle_req_ready", req_ready_o, 1);
      check_eq("idle_out_valid", out_valid_o, 0);
      check_eq("idle_cipher_valid", cipher_valid_o, 0);
      pend_v = 1'b0;
      @(posedge clk_i); #1;
    end
  endtask

  // One job: cycle 0 presents the request; the model tracks issues and pops by block index.
  task automatic run_job(input logic [31:0] nonce, input int len, input int dv_pct, input int or_pct,
                         input int bp_lo, input int bp_hi, input bit strict,
                         input int abort_after, input int stray_at);
    int  iss = 0;
    int  pops = 0;
    int  cyc = 0;
    bit  done = 1'b0;
    bit  pop_now;
    while (!done) begin
      req_valid_i  = (cyc == 0);
      req_nonce_i  = nonce;
      req_len_i    = len[7:0];
      data_valid_i = ($urandom_range(99) < dv_pct);
      out_ready_i  = (cyc >= bp_lo && cyc <= bp_hi) ? 1'b0 : ($urandom_range(99) < or_pct);
      data_i       = fixed_data ? 64'h0123_4567_89AB_CDEF : rnd64();
      cipher_valid_i = pend_v;
      cipher_data_i  = pend_v ? pend_d : rnd64();
      if (cyc == stray_at && !pend_v) cipher_valid_i = 1'b1;
      #3;
      if (cyc == 0) check_eq("req_ready_idle", req_ready_o, 1);
      else          check_eq("req_ready_run", req_ready_o, 0);
      if (cyc == stray_at) begin
        check_eq("stray_slot", {pend_v, cipher_valid_o}, 0);
        exp_err = 1'b1;
      end
      check_eq("ov_needs_dv", out_valid_o & ~data_valid_i, 0);
      if (data_valid_i) check_eq("data_ready", data_ready_o, out_valid_o & out_ready_i);
      pop_now = out_valid_o && out_ready_i;
      if (cipher_valid_o) begin
        check_eq("iss_data", cipher_data_o, {nonce, 32'(iss)});
        check_eq("iss_bound", iss < len, 1);
        check_eq("iss_credit", (iss - pops - int'(pop_now)) < 2, 1);
        if (strict) check_eq("iss_cycle", cyc, 1 + iss);
        iss++;
      end
      if (pop_now) begin
        check_eq("out_data", out_data_o, data_i ^ ks({nonce, 32'(pops)}));
        check_eq("out_last", out_last_o, pops == len - 1);
        if (strict) check_eq("out_cycle", cyc, 2 + LAT + pops);
        last_out = out_data_o;
        pops++;
        if (pops == len) done = 1'b1;
      end
      if (abort_after > 0 && pops == abort_after) done = 1'b1;
      pend_v = cipher_valid_o;
      pend_d = ks(cipher_data_o);
      cyc++;
      if (cyc > 5000) begin
        check_eq("job_timeout", cyc, 0);
        done = 1'b1;
      end
      @(posedge clk_i); #1;
    end
    req_valid_i = 1'b0;
    if (abort_after == 0) begin
      check_eq("job_issues", iss, len);
      check_eq("err_flag", err_o, exp_err);
      idle_cycles(1);
    end
  endtask

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; req_nonce_i = '0; req_len_i = '0;
    data_valid_i = 1'b0; data_i = '0; out_ready_i = 1'b0;
    cipher_valid_i = 1'b0; cipher_data_i = '0;
    #1;
    reset_dut();
    idle_cycles(2);

    ks_ones = 1'b1; fixed_data = 1'b1;
    run_job(32'h1234_5678, 1, 100, 100, -1, -1, 1'b1, 0, -1);
    check_eq("single_out", last_out, 64'hFEDC_BA98_7654_3210);
    ks_ones = 1'b0; fixed_data = 1'b0;

    run_job($urandom, 4, 100, 100, -1, -1, 1'b1, 0, -1);
    run_job($urandom, 8, 100, 100, 3, 8, 1'b0, 0, -1);

    req_valid_i = 1'b1; req_len_i = 8'd0; req_nonce_i = $urandom;
    data_valid_i = 1'b1; out_ready_i = 1'b1; cipher_valid_i = 1'b0;
    #3;
    check_eq("zero_req_ready", req_ready_o, 1);
    check_eq("zero_cipher_valid", cipher_valid_o, 0);
    @(posedge clk_i); #1;
    idle_cycles(4);

    run_job($urandom, 4, 100, 100, -1, -1, 1'b0, 2, -1);
    rst_i = 1'b1; cipher_valid_i = 1'b0; pend_v = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    cipher_valid_i = 1'b1; cipher_data_i = rnd64();
    req_valid_i = 1'b0; data_valid_i = 1'b1; out_ready_i = 1'b1;
    #3;
    check_eq("post_rst_out_valid", out_valid_o, 0);
    check_eq("post_rst_req_ready", req_ready_o, 1);
    @(posedge clk_i); #1;
    cipher_valid_i = 1'b0;
    #3;
    check_eq("idle_stray_err", err_o, 0);
    check_eq("idle_stray_dropped", out_valid_o, 0);
    @(posedge clk_i); #1;
    run_job($urandom, 1, 100, 100, -1, -1, 1'b1, 0, -1);

    run_job($urandom, 2, 100, 100, 0, 8, 1'b0, 0, 6);
    run_job($urandom, 3, 70, 70, -1, -1, 1'b0, 0, -1);
    reset_dut();
    check_eq("err_cleared", err_o, 0);

    for (int j = 0; j < 10; j++)
      run_job($urandom, $urandom_range(1, 24), $urandom_range(30, 100), $urandom_range(30, 100),
              -1, -1, 1'b0, 0, -1);
    run_job($urandom, 255, 100, 100, -1, -1, 1'b1, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
